// File: rtl/wishbone_bram_responder_if.sv
// Wishbone Classic Pipelined bus between one initiator and the block-RAM responder.
// Signal names follow the Wishbone naming used on the console bus.
interface wishbone_bram_responder_if #(
   parameter int AddressWidth = 12,
   parameter int DataWidth    = 32
);
   logic                     CYC;
   logic                     STB;
   logic                     WE;
   logic [AddressWidth-1:0]  ADR;
   logic [DataWidth/8-1:0]   SEL;
   logic [DataWidth-1:0]     DAT_W;
   logic [DataWidth-1:0]     DAT_R;
   logic                     ACK;
   logic                     ERR;
   logic                     STALL;

   modport master (
      output CYC, STB, WE, ADR, SEL, DAT_W,
      input  DAT_R, ACK, ERR, STALL
   );

   modport slave (
      input  CYC, STB, WE, ADR, SEL, DAT_W,
      output DAT_R, ACK, ERR, STALL
   );
endinterface

// File: rtl/wishbone_bram_responder.sv
// Fixed-latency, in-order Wishbone pipelined responder in front of an inferred block RAM.
// Stalls one cycle on a read that hits the address written on the previous edge.
module wishbone_bram_responder #(
   parameter int AddressWidth = 12,
   parameter int DataWidth    = 32,
   parameter int Depth        = 4096,
   parameter int ReadLatency  = 2
) (
   input  logic                    Clk,
   input  logic                    Reset,
   wishbone_bram_responder_if.slave bus
);
   localparam int Lanes    = DataWidth / 8;
   localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

   logic                    in_range;
   logic                    stall;
   logic                    accept;
   logic                    wr_en;
   logic                    rd_en;
   logic [Lanes-1:0]        lane_we;
   logic [IdxWidth-1:0]     mem_idx;

   logic                    haz_valid_reg, haz_valid_next;
   logic [AddressWidth-1:0] haz_adr_reg, haz_adr_next;

   logic [ReadLatency-1:0]  vld_reg, vld_next;
   logic [ReadLatency-1:0]  err_reg, err_next;
   logic [ReadLatency-1:0]  rd_reg, rd_next;

   logic [DataWidth-1:0]    mem [Depth];
   logic [DataWidth-1:0]    ram_q_reg;
   logic [DataWidth-1:0]    data_out;
   logic                    ack;

   assign in_range = {1'b0, bus.ADR} < (AddressWidth + 1)'(Depth);
   assign mem_idx  = bus.ADR[IdxWidth-1:0];

   assign stall = Reset & bus.CYC & bus.STB & ~bus.WE & in_range
                & haz_valid_reg & (bus.ADR == haz_adr_reg);

   assign accept = Reset & bus.CYC & bus.STB & ~stall;
   assign wr_en  = accept & bus.WE & in_range;
   assign rd_en  = accept & ~bus.WE & in_range;

   generate
      for (genvar gi = 0; gi < Lanes; gi++) begin : g_lane
         assign lane_we[gi] = wr_en & bus.SEL[gi];
      end
   endgenerate

   // RAM array: byte-lane writes and a clock-enabled registered read, no reset.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < Lanes; i++) begin
         if (lane_we[i]) begin
            mem[mem_idx][i*8 +: 8] <= bus.DAT_W[i*8 +: 8];
         end
      end
      if (rd_en) begin
         ram_q_reg <= mem[mem_idx];
      end
   end

   // Stage 0 of each shift register is loaded at the acceptance edge.
   always_comb begin
      haz_valid_next = wr_en;
      haz_adr_next   = bus.ADR;
      vld_next[0]    = accept;
      err_next[0]    = accept & ~in_range;
      rd_next[0]     = rd_en;
      for (int k = 1; k < ReadLatency; k++) begin
         vld_next[k] = vld_reg[k-1];
         err_next[k] = err_reg[k-1];
         rd_next[k]  = rd_reg[k-1];
      end
      if (!bus.CYC) begin
         haz_valid_next = 1'b0;
         vld_next       = '0;
         err_next       = '0;
         rd_next        = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         haz_valid_reg <= 1'b0;
         haz_adr_reg   <= '0;
         vld_reg       <= '0;
         err_reg       <= '0;
         rd_reg        <= '0;
      end else begin
         haz_valid_reg <= haz_valid_next;
         haz_adr_reg   <= haz_adr_next;
         vld_reg       <= vld_next;
         err_reg       <= err_next;
         rd_reg        <= rd_next;
      end
   end

   // The RAM output register is the first data stage; ReadLatency-1 more follow.
   generate
      if (ReadLatency == 1) begin : g_no_pipe
         assign data_out = ram_q_reg;
      end else begin : g_pipe
         logic [DataWidth-1:0] pipe_reg [ReadLatency-1];
         always_ff @(posedge Clk) begin
            pipe_reg[0] <= ram_q_reg;
            for (int k = 1; k < ReadLatency - 1; k++) begin
               pipe_reg[k] <= pipe_reg[k-1];
            end
         end
         assign data_out = pipe_reg[ReadLatency-2];
      end
   endgenerate

   // Gating with CYC and Reset suppresses a response in the very cycle of an abort.
   assign ack       = Reset & bus.CYC & vld_reg[ReadLatency-1] & ~err_reg[ReadLatency-1];
   assign bus.ACK   = ack;
   assign bus.ERR   = Reset & bus.CYC & vld_reg[ReadLatency-1] & err_reg[ReadLatency-1];
   assign bus.STALL = stall;
   assign bus.DAT_R = (ack & rd_reg[ReadLatency-1]) ? data_out : '0;
endmodule

// File: tb/tb_wishbone_bram_responder.sv
// Directed bench for wishbone_bram_responder (Depth=3000, ReadLatency=2).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_wishbone_bram_responder;
   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int DEPTH = 3000;
   localparam int LAT   = 2;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   wishbone_bram_responder_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();

   wishbone_bram_responder #(
      .AddressWidth(AW),
      .DataWidth   (DW),
      .Depth       (DEPTH),
      .ReadLatency (LAT)
   ) dut (
      .Clk  (clk),
      .Reset(reset_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic drive(input logic cyc, input logic stb, input logic we,
                        input logic [AW-1:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat);
      bus.CYC   = cyc;
      bus.STB   = stb;
      bus.WE    = we;
      bus.ADR   = adr;
      bus.SEL   = sel;
      bus.DAT_W = dat;
   endtask

   task automatic idle(input logic cyc);
      drive(cyc, 1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // {ACK, ERR, STALL} packed for compact comparisons
   function automatic logic [31:0] hs();
      return 32'({bus.ACK, bus.ERR, bus.STALL});
   endfunction

   // One isolated request: no stall, nothing at latency 1, response at latency 2.
   task automatic single(input string tag, input logic we, input logic [AW-1:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat,
                         input logic exp_err, input logic chk_dat, input logic [31:0] exp_dat);
      drive(1'b1, 1'b1, we, adr, sel, dat);
      @(negedge clk);
      check({tag, " stall"}, hs(), 32'b000);
      next_cycle();
      idle(1'b1);
      @(negedge clk);
      check({tag, " early"}, hs(), 32'b000);
      next_cycle();
      @(negedge clk);
      check({tag, " resp"}, hs(), exp_err ? 32'b010 : 32'b100);
      if (chk_dat) check({tag, " data"}, bus.DAT_R, exp_dat);
      next_cycle();
      idle(1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset then idle
      reset_n = 1'b0;
      idle(1'b0);
      next_cycle();
      next_cycle();
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("idle hs %0d", i), hs(), 32'b000);
         check($sformatf("idle dat %0d", i), bus.DAT_R, 32'h0);
         next_cycle();
      end

      // Read-after-write hazard
      drive(1'b1, 1'b1, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
      @(negedge clk);
      check("raw wr stall", hs(), 32'b000);
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
      @(negedge clk);
      check("raw rd stalled", hs(), 32'b001);
      next_cycle();
      @(negedge clk);
      check("raw rd accepted + wr ack", hs(), 32'b100);
      next_cycle();
      idle(1'b1);
      @(negedge clk);
      check("raw gap", hs(), 32'b000);
      next_cycle();
      @(negedge clk);
      check("raw rd ack", hs(), 32'b100);
      check("raw rd data", bus.DAT_R, 32'hDEADBEEF);
      next_cycle();
      idle(1'b0);
      next_cycle();

      // Byte lanes
      single("bl wr full", 1'b1, 12'd5, 4'hF, 32'h11223344, 1'b0, 1'b0, 32'h0);
      single("bl wr sel5", 1'b1, 12'd5, 4'h5, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0);
      single("bl rd", 1'b0, 12'd5, 4'h0, 32'h0, 1'b0, 1'b1, 32'h11BB33DD);
      single("bl wr sel0", 1'b1, 12'd5, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);
      single("bl rd after sel0", 1'b0, 12'd5, 4'h0, 32'h0, 1'b0, 1'b1, 32'h11BB33DD);

      // Streaming reads
      for (int i = 0; i < 8; i++) begin
         single($sformatf("pre wr %0d", i), 1'b1, 12'(i), 4'hF, 32'(i), 1'b0, 1'b0, 32'h0);
      end
      for (int i = 0; i < 11; i++) begin
         if (i < 8) drive(1'b1, 1'b1, 1'b0, 12'(i), 4'h0, 32'h0);
         else idle(1'b1);
         @(negedge clk);
         if (i >= 2 && i < 10) begin
            check($sformatf("stream hs %0d", i), hs(), 32'b100);
            check($sformatf("stream dat %0d", i), bus.DAT_R, 32'(i - 2));
         end else begin
            check($sformatf("stream hs %0d", i), hs(), 32'b000);
         end
         next_cycle();
      end
      idle(1'b0);
      next_cycle();

      // Range errors
      single("rg wr 2999", 1'b1, 12'd2999, 4'hF, 32'h12345678, 1'b0, 1'b0, 32'h0);
      single("rg wr 3000", 1'b1, 12'd3000, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
      single("rg rd 3000", 1'b0, 12'd3000, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0);
      single("rg rd 2999", 1'b0, 12'd2999, 4'h0, 32'h0, 1'b0, 1'b1, 32'h12345678);

      // Abort by CYC drop
      drive(1'b1, 1'b1, 1'b0, 12'd1, 4'h0, 32'h0);
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 12'd2, 4'h0, 32'h0);
      next_cycle();
      idle(1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("abort hs %0d", i), hs(), 32'b000);
         check($sformatf("abort dat %0d", i), bus.DAT_R, 32'h0);
         next_cycle();
         idle(1'b1);
      end
      idle(1'b0);
      next_cycle();

      // Abort by reset
      drive(1'b1, 1'b1, 1'b0, 12'd1, 4'h0, 32'h0);
      next_cycle();
      drive(1'b1, 1'b1, 1'b0, 12'd2, 4'h0, 32'h0);
      next_cycle();
      idle(1'b1);
      reset_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("rst hs %0d", i), hs(), 32'b000);
         check($sformatf("rst dat %0d", i), bus.DAT_R, 32'h0);
         next_cycle();
         reset_n = 1'b1;
      end
      idle(1'b0);
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
